// File: rtl/ccs_multi_pkg.sv
// Shared types and helpers for the multi-station launcher control system.
package ccs_multi_pkg;

  // Per-station operating state.
  typedef enum logic [1:0] {
    ST_READY     = 2'd0,
    ST_COOLDOWN  = 2'd1,
    ST_RELOADING = 2'd2
  } ccs_state_e;

  // Binary to 2-digit BCD; anything above 99 is shown as 99.
  function automatic logic [7:0] bin2bcd(input logic [7:0] bin);
    logic [7:0] sat;
    sat = (bin > 8'd99) ? 8'd99 : bin;
    return {4'(sat / 8'd10), 4'(sat % 8'd10)};
  endfunction

endpackage

// File: rtl/ccs_multi_channel.sv
// One launcher station: state machine, shared cooldown/reload timer and
// ammunition counter.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_READY     | idle; may launch (armed) or start reloading (disarmed)
//   ST_COOLDOWN  | blocked after a launch until the timer has run down
//   ST_RELOADING | one rocket added every RELOAD_TICKS ticks until full
module ccs_multi_channel
  import ccs_multi_pkg::*;
#(
  parameter int AMMO_MAX       = 8,
  parameter int AMMO_W         = 4,
  parameter int COOLDOWN_TICKS = 4,
  parameter int RELOAD_TICKS   = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              tick_i,
  input  logic              armed_i,
  input  logic              fire_rise_i,
  input  logic              reload_rise_i,
  input  logic              sel_i,
  output logic              launch_o,
  output logic [AMMO_W-1:0] ammo_o,
  output logic              busy_o
);

  localparam int TIMER_MAX = (COOLDOWN_TICKS > RELOAD_TICKS) ? COOLDOWN_TICKS : RELOAD_TICKS;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] T_COOL   = TIMER_W'(COOLDOWN_TICKS);
  localparam logic [TIMER_W-1:0] T_RELOAD = TIMER_W'(RELOAD_TICKS);
  localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);
  localparam logic [AMMO_W-1:0]  A_FULL   = AMMO_W'(AMMO_MAX);
  localparam logic [AMMO_W-1:0]  A_LAST   = AMMO_W'(AMMO_MAX - 1);
  localparam logic [AMMO_W-1:0]  A_ONE    = AMMO_W'(1);

  ccs_state_e          state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [AMMO_W-1:0]   ammo_q, ammo_d;
  logic                launch_q, launch_d;
  logic                want_fire;
  logic                want_reload;

  // Mode gating: fire only while armed, reload only while disarmed.
  assign want_fire   = armed_i & fire_rise_i & sel_i & (ammo_q != '0);
  assign want_reload = ~armed_i & reload_rise_i & (ammo_q < A_FULL);

  // Next-state, timer and ammunition update.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    ammo_d   = ammo_q;
    launch_d = 1'b0;
    unique case (state_q)
      ST_READY: begin
        if (want_fire) begin
          state_d  = ST_COOLDOWN;
          timer_d  = T_COOL;
          ammo_d   = ammo_q - A_ONE;
          launch_d = 1'b1;
        end else if (want_reload) begin
          state_d = ST_RELOADING;
          timer_d = T_RELOAD;
        end
      end
      ST_COOLDOWN: begin
        if (want_reload) begin
          state_d = ST_RELOADING;
          timer_d = T_RELOAD;
        end else if (timer_q == '0) begin
          state_d = ST_READY;
        end else if (tick_i) begin
          timer_d = timer_q - T_ONE;
        end
      end
      ST_RELOADING: begin
        // armed is deliberately not looked at here: a started reload completes.
        if (tick_i) begin
          if (timer_q <= T_ONE) begin
            timer_d = T_RELOAD;
            if (ammo_q < A_FULL) ammo_d = ammo_q + A_ONE;
            if (ammo_q >= A_LAST) state_d = ST_READY;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
      end
      default: begin
        state_d = ST_READY;
        timer_d = '0;
      end
    endcase
  end

  // State, timer, ammunition and launch-pulse registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_READY;
      timer_q  <= '0;
      ammo_q   <= A_FULL;
      launch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      ammo_q   <= ammo_d;
      launch_q <= launch_d;
    end
  end

  assign launch_o = launch_q;
  assign ammo_o   = ammo_q;
  assign busy_o   = (state_q != ST_READY);

endmodule

// File: rtl/ccs_multi.sv
// Central control for N launcher stations: radar target selection, button
// edge detection, per-station channels and the BCD rocket total.
module ccs_multi
  import ccs_multi_pkg::*;
#(
  parameter int N_STATIONS     = 3,
  parameter int AMMO_MAX       = 8,
  parameter int AMMO_W         = 4,
  parameter int COOLDOWN_TICKS = 4,
  parameter int RELOAD_TICKS   = 16
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       tick_i,
  input  logic                       armed_i,
  input  logic                       fire_i,
  input  logic                       reload_i,
  input  logic [N_STATIONS-1:0]      radar_i,
  output logic [N_STATIONS-1:0]      launch_o,
  output logic [N_STATIONS-1:0]      target_sel_o,
  output logic                       conflict_o,
  output logic [N_STATIONS*AMMO_W-1:0] ammo_o,
  output logic [N_STATIONS-1:0]      busy_o,
  output logic [7:0]                 total_bcd_o
);

  localparam logic [7:0] TOTAL_RST = bin2bcd(8'(N_STATIONS * AMMO_MAX));

  logic [N_STATIONS-1:0] target_sel_q, target_sel_d;
  logic                  conflict_q, conflict_d;
  logic                  fire_q, reload_q;
  logic                  fire_rise, reload_rise;
  logic [7:0]            total_q, total_d;
  logic [7:0]            ammo_sum;
  logic [3:0]            radar_cnt;

  // Edges are taken every clock; the previous-level registers clear on reset,
  // and target_sel is also clear then, so a held button cannot launch.
  assign fire_rise   = fire_i & ~fire_q;
  assign reload_rise = reload_i & ~reload_q;

  // Target selection: a single radar hit selects, several hits flag a conflict.
  always_comb begin
    radar_cnt = '0;
    for (int i = 0; i < N_STATIONS; i++) begin
      radar_cnt = radar_cnt + 4'(radar_i[i]);
    end
    target_sel_d = (radar_cnt == 4'd1) ? radar_i : '0;
    conflict_d   = (radar_cnt > 4'd1);
  end

  // Rocket total across all stations, converted to saturating BCD.
  always_comb begin
    ammo_sum = '0;
    for (int i = 0; i < N_STATIONS; i++) begin
      ammo_sum = ammo_sum + 8'(ammo_o[i*AMMO_W +: AMMO_W]);
    end
    total_d = bin2bcd(ammo_sum);
  end

  // Selection, edge-detect and total registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      target_sel_q <= '0;
      conflict_q   <= 1'b0;
      fire_q       <= 1'b0;
      reload_q     <= 1'b0;
      total_q      <= TOTAL_RST;
    end else begin
      target_sel_q <= target_sel_d;
      conflict_q   <= conflict_d;
      fire_q       <= fire_i;
      reload_q     <= reload_i;
      total_q      <= total_d;
    end
  end

  for (genvar g = 0; g < N_STATIONS; g++) begin : g_ch
    ccs_multi_channel #(
      .AMMO_MAX      (AMMO_MAX),
      .AMMO_W        (AMMO_W),
      .COOLDOWN_TICKS(COOLDOWN_TICKS),
      .RELOAD_TICKS  (RELOAD_TICKS)
    ) u_ch (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .tick_i       (tick_i),
      .armed_i      (armed_i),
      .fire_rise_i  (fire_rise),
      .reload_rise_i(reload_rise),
      .sel_i        (target_sel_q[g]),
      .launch_o     (launch_o[g]),
      .ammo_o       (ammo_o[g*AMMO_W +: AMMO_W]),
      .busy_o       (busy_o[g])
    );
  end

  assign target_sel_o = target_sel_q;
  assign conflict_o   = conflict_q;
  assign total_bcd_o  = total_q;

endmodule

// File: tb/tb_ccs_multi.sv
// Directed plus randomized bench for ccs_multi at default parameters.
module tb_ccs_multi;

  localparam int N    = 3;
  localparam int AW   = 4;
  localparam int AMAX = 8;
  localparam int CT   = 4;
  localparam int RT   = 16;

  logic             clock_i = 1'b0;
  logic             reset_i, tick_i, armed_i, fire_i, reload_i;
  logic [N-1:0]     radar_i, launch_o, target_sel_o, busy_o;
  logic             conflict_o;
  logic [N*AW-1:0]  ammo_o;
  logic [7:0]       total_bcd_o;

  int checks = 0;
  int errors = 0;

  // Reference model: rockets per station and ticks elapsed since its last launch.
  int ammo_m[N];
  int since_m[N];

  ccs_multi dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .tick_i      (tick_i),
    .armed_i     (armed_i),
    .fire_i      (fire_i),
    .reload_i    (reload_i),
    .radar_i     (radar_i),
    .launch_o    (launch_o),
    .target_sel_o(target_sel_o),
    .conflict_o  (conflict_o),
    .ammo_o      (ammo_o),
    .busy_o      (busy_o),
    .total_bcd_o (total_bcd_o)
  );

  always #5 clock_i = ~clock_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input bit t);
    tick_i = t;
    @(posedge clock_i);
    #1;
    tick_i = 1'b0;
    if (t) for (int i = 0; i < N; i++) since_m[i]++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd_of(input int v);
    int s;
    s = (v > 99) ? 99 : v;
    return 8'((s / 10) * 16 + (s % 10));
  endfunction

  function automatic logic [31:0] ammo_of(input int i);
    return 32'(ammo_o[i*AW +: AW]);
  endfunction

  function automatic int sum_m();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += ammo_m[i];
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ammo_m[i]  = AMAX;
      since_m[i] = 1000;
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step(0);
    reset_i = 1'b0;
    step(0);
    model_reset();
  endtask

  // Fire pulse: launch cycle, then the following cycle.
  task automatic fire_pulse(output logic [N-1:0] l1, output logic [N-1:0] l2,
                            output logic [7:0] t1, output logic [7:0] t2);
    fire_i = 1'b1;
    step(0);
    l1 = launch_o;
    t1 = total_bcd_o;
    fire_i = 1'b0;
    step(0);
    l2 = launch_o;
    t2 = total_bcd_o;
  endtask

  // Expected launch for an armed fire with radar pattern r (no reloads pending).
  task automatic model_fire(input logic [N-1:0] r, output logic [N-1:0] exp);
    exp = '0;
    if ($countones(r) == 1) begin
      for (int i = 0; i < N; i++) begin
        if (r[i] && ammo_m[i] > 0 && since_m[i] >= CT) begin
          exp[i]     = 1'b1;
          ammo_m[i]  = ammo_m[i] - 1;
          since_m[i] = 0;
        end
      end
    end
  endtask

  initial begin
    logic [N-1:0] l1, l2, exp_l, exp_b, r;
    logic [7:0]   t1, t2;
    int           w;

    reset_i = 1'b1; tick_i = 1'b0; armed_i = 1'b1;
    fire_i = 1'b0;  reload_i = 1'b0; radar_i = '0;
    model_reset();
    step(0);
    step(0);

    // 1: reset values
    for (int i = 0; i < N; i++) check("rst_ammo", ammo_of(i), 32'(AMAX));
    check("rst_total", 32'(total_bcd_o), 32'h24);
    check("rst_launch", 32'(launch_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_sel", 32'(target_sel_o), 0);
    check("rst_conflict", 32'(conflict_o), 0);
    reset_i = 1'b0;
    step(0);

    // 2: single target on station 1
    radar_i = 3'b010;
    step(0);
    check("t2_sel", 32'(target_sel_o), 32'b010);
    check("t2_conflict", 32'(conflict_o), 0);
    fire_pulse(l1, l2, t1, t2);
    check("t2_launch", 32'(l1), 32'b010);
    check("t2_launch_end", 32'(l2), 0);
    check("t2_ammo1", ammo_of(1), 7);
    check("t2_total_lag", 32'(t1), 32'h24);
    check("t2_total", 32'(t2), 32'h23);
    step(1);
    step(1);
    fire_pulse(l1, l2, t1, t2);
    check("t2_cool_fire", 32'(l1 | l2), 0);
    check("t2_cool_busy", 32'(busy_o), 32'b010);
    check("t2_cool_ammo1", ammo_of(1), 7);

    // 3: conflict and no target
    radar_i = 3'b011;
    step(0);
    check("t3_conflict", 32'(conflict_o), 1);
    check("t3_sel", 32'(target_sel_o), 0);
    fire_pulse(l1, l2, t1, t2);
    check("t3_conf_fire", 32'(l1 | l2), 0);
    radar_i = 3'b000;
    step(0);
    check("t3_none_conflict", 32'(conflict_o), 0);
    check("t3_none_sel", 32'(target_sel_o), 0);
    fire_pulse(l1, l2, t1, t2);
    check("t3_none_fire", 32'(l1 | l2), 0);

    // 4: drain station 0 from a fresh start
    do_reset();
    armed_i = 1'b1;
    radar_i = 3'b001;
    step(0);
    for (int k = 0; k < AMAX; k++) begin
      fire_pulse(l1, l2, t1, t2);
      check("t4_launch", 32'(l1), 32'b001);
      check("t4_launch_end", 32'(l2), 0);
      check("t4_total", 32'(t2), 32'(bcd_of(2 * AMAX + AMAX - 1 - k)));
      repeat (CT + 1) step(1);
      step(0);
    end
    check("t4_ammo0", ammo_of(0), 0);
    check("t4_total_end", 32'(total_bcd_o), 32'h16);
    check("t4_busy_end", 32'(busy_o), 0);
    fire_pulse(l1, l2, t1, t2);
    check("t4_empty_fire", 32'(l1 | l2), 0);
    check("t4_empty_ammo0", ammo_of(0), 0);

    // 5: reload station 0; fire mid-reload after re-arming is ignored
    armed_i = 1'b0;
    reload_i = 1'b1;
    step(0);
    reload_i = 1'b0;
    check("t5_busy_start", 32'(busy_o), 32'b001);
    for (int k = 1; k <= AMAX * RT; k++) begin
      step(1);
      check("t5_ammo0", ammo_of(0), 32'(k / RT));
      check("t5_busy0", 32'(busy_o[0]), 32'(k < AMAX * RT));
      if (k == 40) begin
        armed_i = 1'b1;
        fire_pulse(l1, l2, t1, t2);
        check("t5_reload_fire", 32'(l1 | l2), 0);
        check("t5_reload_busy", 32'(busy_o[0]), 1);
      end
    end
    step(0);
    check("t5_total", 32'(total_bcd_o), 32'h24);

    // 6: reset during a reload, with fire held across release
    fire_pulse(l1, l2, t1, t2);
    check("t6_launch", 32'(l1), 32'b001);
    repeat (CT + 1) step(1);
    step(0);
    armed_i = 1'b0;
    reload_i = 1'b1;
    step(0);
    reload_i = 1'b0;
    repeat (5) step(1);
    check("t6_mid_busy", 32'(busy_o[0]), 1);
    check("t6_mid_ammo0", ammo_of(0), 7);
    reset_i = 1'b1;
    fire_i = 1'b1;
    armed_i = 1'b1;
    radar_i = 3'b001;
    step(0);
    for (int i = 0; i < N; i++) check("t6_rst_ammo", ammo_of(i), 32'(AMAX));
    check("t6_rst_busy", 32'(busy_o), 0);
    check("t6_rst_total", 32'(total_bcd_o), 32'h24);
    check("t6_rst_launch", 32'(launch_o), 0);
    reset_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(0);
      check("t6_held_fire", 32'(launch_o), 0);
    end
    fire_i = 1'b0;
    step(0);
    check("t6_ammo0_kept", ammo_of(0), 32'(AMAX));
    model_reset();

    // Randomized armed operation against the model.
    armed_i = 1'b1;
    for (int op = 0; op < 30; op++) begin
      w = int'($urandom_range(0, 6));
      repeat (w) step(1);
      step(0);
      exp_b = '0;
      for (int i = 0; i < N; i++) exp_b[i] = (since_m[i] < CT);
      check("rnd_busy", 32'(busy_o), 32'(exp_b));
      if ($urandom_range(0, 3) == 0) begin
        reload_i = 1'b1;
        step(0);
        reload_i = 1'b0;
        check("rnd_armed_reload", 32'(busy_o), 32'(exp_b));
      end
      r = 3'($urandom_range(0, 7));
      radar_i = r;
      step(0);
      check("rnd_sel", 32'(target_sel_o), ($countones(r) == 1) ? 32'(r) : 0);
      check("rnd_conflict", 32'(conflict_o), 32'($countones(r) > 1));
      model_fire(r, exp_l);
      fire_pulse(l1, l2, t1, t2);
      check("rnd_launch", 32'(l1), 32'(exp_l));
      check("rnd_launch_end", 32'(l2), 0);
      check("rnd_total", 32'(t2), 32'(bcd_of(sum_m())));
      for (int i = 0; i < N; i++) check("rnd_ammo", ammo_of(i), 32'(ammo_m[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
